// File: rtl/verlet_pkg.sv
// Shared encodings and clamp helper for the Verlet point-mass node.
package verlet_pkg;

    typedef enum logic [1:0] {
        OP_STEP    = 2'b00,
        OP_CORRECT = 2'b01,
        OP_PIN     = 2'b10,
        OP_UNPIN   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_UPD  = 2'b10
    } state_t;

    // Callers sign-extend any narrower operand to CLAMP_W and size-cast the result back.
    localparam int CLAMP_W = 64;

    function automatic logic signed [CLAMP_W-1:0] clamp_val(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/verlet_axis.sv
// One axis of the node: damped velocity multiply, position update with clamp,
// constraint correction and pinning.
module verlet_axis
    import verlet_pkg::*;
#(
    parameter int W          = 32,
    parameter int INIT       = 0,
    parameter int GRAV       = 0,
    parameter int DAMP_NUM   = 256,
    parameter int DAMP_SHIFT = 8,
    parameter int MIN        = 0,
    parameter int MAX        = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mul_en,
    input  logic         upd_en,
    input  logic         corr_en,
    input  logic         pin_en,
    input  logic [W-1:0] arg,
    output logic [W-1:0] cur
);

    localparam int W1 = W + 1;
    localparam int W2 = W + 2;
    localparam int PW = W + 1 + 33;

    logic signed [W-1:0]  cur_q;
    logic signed [W-1:0]  prev_q;
    logic signed [W2-1:0] vs_q;

    logic signed [W1-1:0] vel;
    logic signed [PW-1:0] prod;
    logic signed [W2-1:0] vs_d;
    logic signed [W2-1:0] sum;
    logic signed [W-1:0]  upd_val;
    logic                 clip;
    logic signed [W1-1:0] corr_sum;
    logic signed [W-1:0]  corr_val;
    logic signed [W-1:0]  pin_val;

    assign vel  = W1'(cur_q) - W1'(prev_q);
    assign prod = PW'(vel) * PW'(DAMP_NUM);
    assign vs_d = W2'(prod >>> DAMP_SHIFT);

    assign sum     = W2'(cur_q) + vs_q + W2'(GRAV);
    assign upd_val = W'(clamp_val(CLAMP_W'(sum), CLAMP_W'(MIN), CLAMP_W'(MAX)));
    assign clip    = (sum < W2'(MIN)) || (sum > W2'(MAX));

    assign corr_sum = W1'(cur_q) + W1'($signed(arg));
    assign corr_val = W'(clamp_val(CLAMP_W'(corr_sum), CLAMP_W'(MIN), CLAMP_W'(MAX)));
    assign pin_val  = W'(clamp_val(CLAMP_W'($signed(arg)), CLAMP_W'(MIN), CLAMP_W'(MAX)));

    // A clamped axis loses its velocity: prev follows the clamped position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q  <= W'(INIT);
            prev_q <= W'(INIT);
            vs_q   <= '0;
        end else begin
            if (mul_en)
                vs_q <= vs_d;
            if (upd_en) begin
                cur_q  <= upd_val;
                prev_q <= clip ? upd_val : cur_q;
            end else if (pin_en) begin
                cur_q  <= pin_val;
                prev_q <= pin_val;
            end else if (corr_en) begin
                cur_q <= corr_val;
            end
        end
    end

    assign cur = cur_q;

endmodule

// File: rtl/verlet_node_param.sv
// Parametrised Verlet point-mass node: command handshake, sequencing FSM and
// two axis datapaths (gravity applies to y only).
//
// state   | meaning
// IDLE    | ready for a command; CORRECT/PIN/UNPIN and pinned STEP finish here
// MUL     | damped velocity product registered per axis
// UPD     | position update with clamp; done asserted on exit
module verlet_node_param
    import verlet_pkg::*;
#(
    parameter int W          = 32,
    parameter int INIT_X     = 200,
    parameter int INIT_Y     = 10,
    parameter int GRAV_Y     = 1,
    parameter int DAMP_NUM   = 256,
    parameter int DAMP_SHIFT = 8,
    parameter int MIN_X      = 0,
    parameter int MAX_X      = 1023,
    parameter int MIN_Y      = 0,
    parameter int MAX_Y      = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] arg_x,
    input  logic [W-1:0] arg_y,
    output logic         done,
    output logic         pinned,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_y
);

    state_t state;
    state_t state_next;
    logic   done_next;
    logic   pinned_next;
    logic   mul_en;
    logic   upd_en;
    logic   corr_en;
    logic   pin_en;

    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            pinned <= 1'b0;
        end else begin
            state  <= state_next;
            done   <= done_next;
            pinned <= pinned_next;
        end
    end

    // In IDLE cmd_ready is high, so cmd_valid alone means acceptance.
    always_comb begin
        state_next  = state;
        done_next   = 1'b0;
        pinned_next = pinned;
        mul_en      = 1'b0;
        upd_en      = 1'b0;
        corr_en     = 1'b0;
        pin_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_STEP: begin
                            if (pinned)
                                done_next = 1'b1;
                            else
                                state_next = ST_MUL;
                        end
                        OP_CORRECT: begin
                            done_next = 1'b1;
                            corr_en   = !pinned;
                        end
                        OP_PIN: begin
                            done_next   = 1'b1;
                            pin_en      = 1'b1;
                            pinned_next = 1'b1;
                        end
                        OP_UNPIN: begin
                            done_next   = 1'b1;
                            pinned_next = 1'b0;
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_MUL: begin
                mul_en     = 1'b1;
                state_next = ST_UPD;
            end
            ST_UPD: begin
                upd_en     = 1'b1;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    verlet_axis #(
        .W(W), .INIT(INIT_X), .GRAV(0), .DAMP_NUM(DAMP_NUM),
        .DAMP_SHIFT(DAMP_SHIFT), .MIN(MIN_X), .MAX(MAX_X)
    ) u_axis_x (
        .clk(clk), .reset(reset), .mul_en(mul_en), .upd_en(upd_en),
        .corr_en(corr_en), .pin_en(pin_en), .arg(arg_x), .cur(out_x)
    );

    verlet_axis #(
        .W(W), .INIT(INIT_Y), .GRAV(GRAV_Y), .DAMP_NUM(DAMP_NUM),
        .DAMP_SHIFT(DAMP_SHIFT), .MIN(MIN_Y), .MAX(MAX_Y)
    ) u_axis_y (
        .clk(clk), .reset(reset), .mul_en(mul_en), .upd_en(upd_en),
        .corr_en(corr_en), .pin_en(pin_en), .arg(arg_y), .cur(out_y)
    );

endmodule
